// File: rtl/registers_bank_pkg.sv
// Shared types and constants for the multi-port register bank.
// Holds the FSM state type, default widths and the slice helper.
package registers_bank_pkg;

    typedef enum logic {
        RB_CLEAR = 1'b0,
        RB_RUN   = 1'b1
    } rb_state_t;

    localparam int RB_DATA_WIDTH = 32;
    localparam int RB_ADDR_WIDTH = 5;

    // Low bit of element idx inside a flattened vector of width-bit elements.
    function automatic int rb_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/registers_bank_read_port.sv
// One synchronous read port of the register bank.
// Resolves zero register and write bypass, then registers the result.
module registers_bank_read_port
    import registers_bank_pkg::*;
#(
    parameter int DATA_WIDTH = RB_DATA_WIDTH,
    parameter int ADDR_WIDTH = RB_ADDR_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write_ok,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH],
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    logic [DATA_WIDTH-1:0] read_value;

    // Select the value a read of this address would capture this cycle.
    always_comb begin
        read_value = mem[address];
        if (ZERO_REG != 0 && address == '0) begin
            read_value = '0;
        end else if (write_ok && write_address == address) begin
            read_value = in_data;
        end
    end

    // Capture data on an accepted read; data holds otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (run && enable) begin
            out_data  <= read_value;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/registers_bank_mp.sv
// Multi-port register bank: N read ports, one write port.
// Self-clears one entry per cycle after reset before accepting accesses.
module registers_bank_mp
    import registers_bank_pkg::*;
#(
    parameter int DATA_WIDTH = RB_DATA_WIDTH,
    parameter int ADDR_WIDTH = RB_ADDR_WIDTH,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable_write,
    input  logic [ADDR_WIDTH-1:0]            write_address,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [READ_PORTS-1:0]            enable_read,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
    output logic [READ_PORTS*DATA_WIDTH-1:0] out_data,
    output logic [READ_PORTS-1:0]            out_valid,
    output logic                             ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    rb_state_t             state;
    logic [ADDR_WIDTH:0]   clear_ptr;
    logic [ADDR_WIDTH:0]   clear_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  run;
    logic                  write_ok;

    assign run        = (state == RB_RUN);
    assign ready      = run;
    assign clear_next = clear_ptr + 1'b1;
    assign write_ok   = run && enable_write
                        && !(ZERO_REG != 0 && write_address == '0);

    // Walk clear_ptr through the array; carry into the top bit ends CLEAR.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RB_CLEAR;
            clear_ptr <= '0;
        end else if (state == RB_CLEAR) begin
            clear_ptr <= clear_next;
            if (clear_next[ADDR_WIDTH]) begin
                state <= RB_RUN;
            end
        end
    end

    // Array update: zero fill while clearing, accepted writes while running.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (!run) begin
                mem[clear_ptr[ADDR_WIDTH-1:0]] <= '0;
            end else if (write_ok) begin
                mem[write_address] <= in_data;
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        registers_bank_read_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .ZERO_REG  (ZERO_REG)
        ) u_port (
            .clock        (clock),
            .reset        (reset),
            .run          (run),
            .enable       (enable_read[p]),
            .address      (read_address[rb_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH]),
            .write_ok     (write_ok),
            .write_address(write_address),
            .in_data      (in_data),
            .mem          (mem),
            .out_data     (out_data[rb_lsb(p, DATA_WIDTH) +: DATA_WIDTH]),
            .out_valid    (out_valid[p])
        );
    end

endmodule

// File: tb/tb_registers_bank_mp.sv
// Bench for registers_bank_mp: default build plus a 16x8, 3-port,
// no-zero-register build, driven on falling edges.
module tb_registers_bank_mp;

    typedef struct {
        string        name;
        logic [127:0] data;
        logic [3:0]   valid;
    } exp_t;

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ev;
    } vec_t;

    logic clk;

    logic        reset_a;
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic [1:0]  re_a;
    logic [9:0]  ra_a;
    logic [63:0] od_a;
    logic [1:0]  ov_a;
    logic        rdy_a;

    logic        reset_b;
    logic        we_b;
    logic [2:0]  wa_b;
    logic [15:0] wd_b;
    logic [2:0]  re_b;
    logic [8:0]  ra_b;
    logic [47:0] od_b;
    logic [2:0]  ov_b;
    logic        rdy_b;

    exp_t sb_a[$];
    exp_t sb_b[$];
    vec_t vecs[12];

    int passed = 0;
    int total  = 0;

    registers_bank_mp #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .READ_PORTS(2),
        .ZERO_REG  (1)
    ) dut_a (
        .clock        (clk),
        .reset        (reset_a),
        .enable_write (we_a),
        .write_address(wa_a),
        .in_data      (wd_a),
        .enable_read  (re_a),
        .read_address (ra_a),
        .out_data     (od_a),
        .out_valid    (ov_a),
        .ready        (rdy_a)
    );

    registers_bank_mp #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(3),
        .READ_PORTS(3),
        .ZERO_REG  (0)
    ) dut_b (
        .clock        (clk),
        .reset        (reset_b),
        .enable_write (we_b),
        .write_address(wa_b),
        .in_data      (wd_b),
        .enable_read  (re_b),
        .read_address (ra_b),
        .out_data     (od_b),
        .out_valid    (ov_b),
        .ready        (rdy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue_a(input string name, input logic we,
                           input logic [4:0] wa, input logic [31:0] wd,
                           input logic [1:0] re, input logic [4:0] ra0,
                           input logic [4:0] ra1, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [1:0] ev);
        exp_t e;
        we_a = we;
        wa_a = wa;
        wd_a = wd;
        re_a = re;
        ra_a = {ra1, ra0};
        sb_a.push_back('{name, {64'h0, e1, e0}, {2'b00, ev}});
        @(negedge clk);
        we_a = 1'b0;
        re_a = '0;
        e = sb_a.pop_front();
        check({e.name, "_data"}, {64'h0, od_a}, e.data);
        check({e.name, "_valid"}, {124'h0, 2'b00, ov_a}, {124'h0, e.valid});
    endtask

    task automatic issue_b(input string name, input logic we,
                           input logic [2:0] wa, input logic [15:0] wd,
                           input logic [2:0] re, input logic [2:0] ra0,
                           input logic [2:0] ra1, input logic [2:0] ra2,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [2:0] ev);
        exp_t e;
        we_b = we;
        wa_b = wa;
        wd_b = wd;
        re_b = re;
        ra_b = {ra2, ra1, ra0};
        sb_b.push_back('{name, {80'h0, e2, e1, e0}, {1'b0, ev}});
        @(negedge clk);
        we_b = 1'b0;
        re_b = '0;
        e = sb_b.pop_front();
        check({e.name, "_data"}, {80'h0, od_b}, e.data);
        check({e.name, "_valid"}, {124'h0, 1'b0, ov_b}, {124'h0, e.valid});
    endtask

    task automatic wait_ready_a(output int n, output int viol);
        n    = 0;
        viol = 0;
        while (!rdy_a && n < 200) begin
            @(negedge clk);
            n++;
            if (ov_a != 2'b00) viol++;
        end
    endtask

    task automatic wait_ready_b(output int n);
        n = 0;
        while (!rdy_b && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int viol;

        vecs[0]  = '{"basic_write_r3", 1'b1, 5'd3, 32'h12345678, 2'b00,
                     5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
        vecs[1]  = '{"basic_read_r3_r7", 1'b0, 5'd0, 32'h0, 2'b11,
                     5'd3, 5'd7, 32'h12345678, 32'h0, 2'b11};
        vecs[2]  = '{"bypass_r9", 1'b1, 5'd9, 32'hA5A5A5A5, 2'b11,
                     5'd9, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b11};
        vecs[3]  = '{"zero_same_cycle", 1'b1, 5'd0, 32'hFFFFFFFF, 2'b11,
                     5'd0, 5'd0, 32'h0, 32'h0, 2'b11};
        vecs[4]  = '{"zero_next_cycle", 1'b0, 5'd0, 32'h0, 2'b11,
                     5'd0, 5'd9, 32'h0, 32'hA5A5A5A5, 2'b11};
        vecs[5]  = '{"idle_hold", 1'b0, 5'd0, 32'h0, 2'b00,
                     5'd0, 5'd0, 32'h0, 32'hA5A5A5A5, 2'b00};
        vecs[6]  = '{"port0_only", 1'b0, 5'd0, 32'h0, 2'b01,
                     5'd3, 5'd0, 32'h12345678, 32'hA5A5A5A5, 2'b01};
        vecs[7]  = '{"port1_bypass", 1'b1, 5'd3, 32'hCAFEF00D, 2'b10,
                     5'd0, 5'd3, 32'h12345678, 32'hCAFEF00D, 2'b10};
        vecs[8]  = '{"same_addr_both", 1'b0, 5'd0, 32'h0, 2'b11,
                     5'd3, 5'd3, 32'hCAFEF00D, 32'hCAFEF00D, 2'b11};
        vecs[9]  = '{"unwritten_r5_r31", 1'b0, 5'd0, 32'h0, 2'b11,
                     5'd5, 5'd31, 32'h0, 32'h0, 2'b11};
        vecs[10] = '{"bypass_top_addr", 1'b1, 5'd31, 32'h80000001, 2'b11,
                     5'd31, 5'd30, 32'h80000001, 32'h0, 2'b11};
        vecs[11] = '{"read_top_addr", 1'b0, 5'd0, 32'h0, 2'b11,
                     5'd1, 5'd31, 32'h0, 32'h80000001, 2'b11};

        reset_a = 1'b1;
        reset_b = 1'b1;
        we_a = 1'b0; wa_a = '0; wd_a = '0; re_a = '0; ra_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0; re_b = '0; ra_b = '0;
        repeat (2) @(negedge clk);

        check("a_reset_ready", {127'h0, rdy_a}, 128'h0);
        check("a_reset_valid", {126'h0, ov_a}, 128'h0);
        check("a_reset_data", {64'h0, od_a}, 128'h0);
        check("b_reset_ready", {127'h0, rdy_b}, 128'h0);

        we_a = 1'b1;
        wa_a = 5'd1;
        wd_a = 32'h11;
        re_a = 2'b11;
        ra_a = {5'd1, 5'd1};
        reset_a = 1'b0;
        wait_ready_a(n, viol);
        we_a = 1'b0;
        re_a = '0;
        check("a_clear_cycles", 128'(n), 128'd32);
        check("a_lockout_valid", 128'(viol), 128'd0);
        check("a_lockout_data", {64'h0, od_a}, 128'h0);

        issue_a("a_preload_r5", 1'b1, 5'd5, 32'hDEADBEEF, 2'b00,
                5'd0, 5'd0, 32'h0, 32'h0, 2'b00);
        issue_a("a_read_r5_r1", 1'b0, 5'd0, 32'h0, 2'b11,
                5'd5, 5'd1, 32'hDEADBEEF, 32'h0, 2'b11);

        reset_a = 1'b1;
        @(negedge clk);
        check("a_midrun_ready", {127'h0, rdy_a}, 128'h0);
        check("a_midrun_valid", {126'h0, ov_a}, 128'h0);
        check("a_midrun_data", {64'h0, od_a}, 128'h0);
        reset_a = 1'b0;
        wait_ready_a(n, viol);
        check("a_reclear_cycles", 128'(n), 128'd32);
        check("a_reclear_valid", 128'(viol), 128'd0);

        issue_a("a_r5_cleared", 1'b0, 5'd0, 32'h0, 2'b11,
                5'd5, 5'd5, 32'h0, 32'h0, 2'b11);

        for (int i = 0; i < 12; i++) begin
            issue_a(vecs[i].name, vecs[i].we, vecs[i].wa, vecs[i].wd,
                    vecs[i].re, vecs[i].ra0, vecs[i].ra1,
                    vecs[i].e0, vecs[i].e1, vecs[i].ev);
        end

        reset_b = 1'b0;
        repeat (3) @(negedge clk);
        check("b_midclear_ready", {127'h0, rdy_b}, 128'h0);
        reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        wait_ready_b(n);
        check("b_clear_cycles", 128'(n), 128'd8);

        issue_b("b_r0_bypass", 1'b1, 3'd0, 16'h1234, 3'b111,
                3'd0, 3'd0, 3'd0, 16'h1234, 16'h1234, 16'h1234, 3'b111);
        issue_b("b_r0_r7_r5", 1'b1, 3'd5, 16'hBEEF, 3'b111,
                3'd0, 3'd7, 3'd5, 16'h1234, 16'h0, 16'hBEEF, 3'b111);
        issue_b("b_port1_hold", 1'b0, 3'd0, 16'h0, 3'b010,
                3'd0, 3'd5, 3'd0, 16'h1234, 16'hBEEF, 16'hBEEF, 3'b010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
